// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage binary32 -> signed int32 converter.
// Stage 1 classifies the operand and registers the significand and shift amount.
// Stage 2 shifts, rounds to nearest with ties away from zero, negates, and
// registers the result with its invalid/inexact flags.
// Handshake: valid/ready with elastic back-pressure. Bubbles collapse, and a
// full pipe holds at most two operands.

module ftoi_pipe (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic [1:0]  out_flags
);

  // Operand classes decided in stage 1. ClsMinInt is the single exactly
  // representable value at exponent 158, which is -2^31.
  typedef enum logic [2:0] {
    ClsZero,
    ClsSmall,
    ClsNormal,
    ClsSatPos,
    ClsSatNeg,
    ClsMinInt,
    ClsNan
  } cls_e;

  localparam logic [31:0] IntMax = 32'h7FFF_FFFF;
  localparam logic [31:0] IntMin = 32'h8000_0000;

  // Handshake controls.
  logic s1_valid_q;
  logic s2_load;
  logic s1_load;
  logic accept;

  // Stage-1 state.
  logic        s1_sign_q;
  cls_e        s1_cls_q;
  logic [23:0] s1_sig_q;
  logic [4:0]  s1_shamt_q;

  // Stage-1 next-state values, derived from in_x.
  logic        x_sign;
  logic [7:0]  x_exp;
  logic [22:0] x_frac;
  cls_e        cls_d;
  logic [23:0] sig_d;
  logic [4:0]  shamt_d;

  // Stage-2 datapath.
  logic [55:0] wide;
  logic [31:0] mag_trunc;
  logic        rnd_bit;
  logic        sticky;
  logic [31:0] mag;
  logic [31:0] res;
  logic [31:0] y_d;
  logic [1:0]  flags_d;

  // Load enables. A stalled output blocks stage 2, and stage 2 blocks stage 1
  // only when stage 1 is occupied. out_ready reaches in_ready combinationally.
  always_comb begin
    s2_load  = ~out_valid | out_ready;
    s1_load  = ~s1_valid_q | s2_load;
    in_ready = s1_load;
    accept   = in_valid & s1_load;
  end

  // Classify the incoming operand and prepare the significand and shift amount.
  always_comb begin
    x_sign  = in_x[31];
    x_exp   = in_x[30:23];
    x_frac  = in_x[22:0];
    cls_d   = ClsZero;
    sig_d   = '0;
    shamt_d = '0;
    if (x_exp == 8'hFF && x_frac != 23'd0) begin
      cls_d = ClsNan;
    end else if (x_exp == 8'd0) begin
      cls_d = ClsZero;
    end else if (x_exp <= 8'd125) begin
      cls_d = ClsSmall;
    end else if (x_exp <= 8'd157) begin
      cls_d   = ClsNormal;
      sig_d   = {1'b1, x_frac};
      // e - 126 spans exactly 0..31 here, so modulo-32 arithmetic on the
      // low five exponent bits gives the same value (126 mod 32 = 30).
      shamt_d = x_exp[4:0] - 5'd30;
    end else if (x_sign && x_exp == 8'd158 && x_frac == 23'd0) begin
      cls_d = ClsMinInt;
    end else if (x_sign) begin
      cls_d = ClsSatNeg;
    end else begin
      cls_d = ClsSatPos;
    end
  end

  // Stage-1 register. Valid follows the handshake; data updates only on accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= ClsZero;
      s1_sig_q   <= '0;
      s1_shamt_q <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
      end
      if (accept) begin
        s1_sign_q  <= x_sign;
        s1_cls_q   <= cls_d;
        s1_sig_q   <= sig_d;
        s1_shamt_q <= shamt_d;
      end
    end
  end

  // Shift, round and negate. wide holds value * 2^24, with the integer part in
  // [55:24], the first discarded bit at 23, and the remaining fraction below it.
  always_comb begin
    wide      = {32'd0, s1_sig_q} << s1_shamt_q;
    mag_trunc = wide[55:24];
    rnd_bit   = wide[23];
    sticky    = |wide[22:0];
    // Cannot overflow: the largest magnitude below 2^31 has no fraction bits.
    mag       = mag_trunc + {31'd0, rnd_bit};
    res       = s1_sign_q ? (32'd0 - mag) : mag;
  end

  // Select the final result and flags for the stage-1 class.
  always_comb begin
    y_d     = '0;
    flags_d = 2'b00;
    unique case (s1_cls_q)
      ClsZero: begin
        y_d     = '0;
        flags_d = 2'b00;
      end
      ClsSmall: begin
        y_d     = '0;
        flags_d = 2'b01;
      end
      ClsNormal: begin
        y_d     = res;
        flags_d = {1'b0, rnd_bit | sticky};
      end
      ClsSatPos: begin
        y_d     = IntMax;
        flags_d = 2'b10;
      end
      ClsSatNeg: begin
        y_d     = IntMin;
        flags_d = 2'b10;
      end
      ClsMinInt: begin
        y_d     = IntMin;
        flags_d = 2'b00;
      end
      ClsNan: begin
        y_d     = IntMax;
        flags_d = 2'b10;
      end
      default: begin
        y_d     = '0;
        flags_d = 2'b00;
      end
    endcase
  end

  // Output register. It holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_flags <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        out_y     <= y_d;
        out_flags <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe. It covers directed value tables, back-pressure, random
// traffic with bubbles against an arithmetic reference model, and reset while
// operands are in flight.

module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [1:0]  out_flags;

  ftoi_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic [1:0]  f;
    logic [31:0] cyc;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    recv = 0;
  bit    chk_lat = 1'b0;
  string cur = "reset";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s: observed %h expected %h", cur, tag, obs, expv);
    end
  endtask

  // Reference conversion computed directly from the value: m * 2^(e-150),
  // rounded half away from zero on the magnitude.
  function automatic logic [33:0] ref_conv(input logic [31:0] x);
    logic        s;
    int          e;
    int          k;
    logic [22:0] f;
    longint      m;
    longint      q;
    longint      r;
    longint      mag;
    s = x[31];
    e = int'(x[30:23]);
    f = x[22:0];
    if (e == 255 && f != 23'd0) return {2'b10, 32'h7FFF_FFFF};
    if (e == 0) return 34'd0;
    if (e <= 125) return {2'b01, 32'h0};
    if (e <= 157) begin
      m = longint'({1'b1, f});
      k = e - 150;
      if (k >= 0) begin
        mag = m <<< k;
        r   = 0;
      end else begin
        q   = m >>> (-k);
        r   = m - (q <<< (-k));
        mag = q + ((2 * r >= (longint'(1) <<< (-k))) ? 64'sd1 : 64'sd0);
      end
      return {1'b0, (r != 0), (s ? 32'(-mag) : 32'(mag))};
    end
    if (s && e == 158 && f == 23'd0) return {2'b00, 32'h8000_0000};
    return {2'b10, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
  endfunction

  // One cycle: drive inputs at negedge, then settle. The consumer takes the
  // result and the block accepts the operand on the following posedge.
  task automatic step(input logic v, input logic [31:0] x, input logic [33:0] e,
                      input logic ordy, output logic acc);
    exp_t h;
    exp_t n;
    @(negedge clk);
    in_valid  = v;
    in_x      = x;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      recv++;
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        h = sb.pop_front();
        check("y", 64'(out_y), 64'(h.y));
        check("flags", 64'(out_flags), 64'(h.f));
        if (chk_lat) check("latency", 64'(cyc), 64'(h.cyc + 32'd2));
      end
    end
    acc = v && in_ready;
    if (acc) begin
      n.y   = e[31:0];
      n.f   = e[33:32];
      n.cyc = cyc;
      sb.push_back(n);
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 34'h0, 1'b1, acc);
  endtask

  logic [31:0] bx[5]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h4B00_0001, 32'h0000_0000,
                          32'h8000_0000};
  logic [33:0] be[5]  = '{{2'b00, 32'h1}, {2'b00, 32'hFFFF_FFFF}, {2'b00, 32'h0080_0001},
                          {2'b00, 32'h0}, {2'b00, 32'h0}};
  logic [31:0] dx[13] = '{32'h4020_0000, 32'hC020_0000, 32'h3F00_0000, 32'h3EFF_FFFF,
                          32'h3FA0_0000, 32'h4EFF_FFFF, 32'h4F00_0000, 32'hCF00_0000,
                          32'hCF00_0001, 32'h7F80_0000, 32'hFF80_0000, 32'hFFC0_0000,
                          32'h0000_0001};
  logic [33:0] de[13] = '{{2'b01, 32'h3}, {2'b01, 32'hFFFF_FFFD}, {2'b01, 32'h1},
                          {2'b01, 32'h0}, {2'b01, 32'h1}, {2'b00, 32'h7FFF_FF80},
                          {2'b10, 32'h7FFF_FFFF}, {2'b00, 32'h8000_0000},
                          {2'b10, 32'h8000_0000}, {2'b10, 32'h7FFF_FFFF},
                          {2'b10, 32'h8000_0000}, {2'b10, 32'h7FFF_FFFF}, {2'b00, 32'h0}};
  logic [31:0] fx[8]  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                          32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

  initial begin
    logic        acc;
    logic        v;
    logic        ordy;
    logic [31:0] x;
    logic [31:0] held;
    int          idx;
    int          sent;
    int          recv0;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b0;
    #12;
    check("out_valid", 64'(out_valid), 64'(0));
    check("out_y", 64'(out_y), 64'(0));
    check("out_flags", 64'(out_flags), 64'(0));
    check("in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rstn = 1'b1;

    // Back-to-back basic values with fixed two-edge latency.
    cur     = "basic";
    chk_lat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bx[i], be[i], 1'b1, acc);
      check("accept", 64'(acc), 64'(1));
    end
    drain(4);
    chk_lat = 1'b0;

    // Rounding and range limits.
    cur = "table";
    for (int i = 0; i < 13; i++) step(1'b1, dx[i], de[i], 1'b1, acc);
    drain(4);

    // Back-pressure: stream 1..8, with the consumer stalled for 5 cycles.
    cur   = "bp";
    idx   = 0;
    recv0 = recv;
    held  = '0;
    for (int t = 0; t < 30; t++) begin
      ordy = !(t >= 4 && t < 9);
      v    = (idx < 8);
      x    = v ? fx[idx] : 32'h0;
      step(v, x, {2'b00, 32'(idx + 1)}, ordy, acc);
      if (t == 4) held = out_y;
      if (t > 4 && t < 9) check("stall_hold", 64'(out_y), 64'(held));
      if (t >= 6 && t < 9) check("stall_ready", 64'(in_ready), 64'(0));
      if (acc) idx++;
    end
    check("count", 64'(recv - recv0), 64'(8));

    // Random operands with input and output bubbles.
    cur  = "rand";
    sent = 0;
    for (int t = 0; t < 60000 && sent < 10000; t++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) x = $urandom;
      else x = {1'($urandom), 8'($urandom_range(120, 160)), 23'($urandom)};
      ordy = ($urandom_range(0, 3) != 0);
      step(v, x, ref_conv(x), ordy, acc);
      if (acc) sent++;
    end
    check("sent", 64'(sent), 64'(10000));
    drain(10);
    check("sb_empty", 64'(sb.size()), 64'(0));

    // Asynchronous reset with two operands in flight.
    cur = "rst";
    step(1'b1, 32'h3F80_0000, ref_conv(32'h3F80_0000), 1'b0, acc);
    step(1'b1, 32'h4000_0000, ref_conv(32'h4000_0000), 1'b0, acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_valid", 64'(out_valid), 64'(1));
    #1;
    rstn = 1'b0;
    #1;
    check("out_valid", 64'(out_valid), 64'(0));
    check("out_y", 64'(out_y), 64'(0));
    sb.delete();
    @(negedge clk);
    rstn  = 1'b1;
    recv0 = recv;
    step(1'b1, 32'h40E0_0000, {2'b00, 32'd7}, 1'b1, acc);
    check("accept", 64'(acc), 64'(1));
    drain(5);
    check("count", 64'(recv - recv0), 64'(1));
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ftoi_pipe.md
# ftoi_pipe

Pipelined single-precision float to signed 32-bit integer converter for the FPU conversion path, the inverse of the integer-to-float stage. It accepts IEEE-754 binary32 operands over a valid/ready handshake and delivers two's-complement results plus exception flags two clock edges later. It sustains one conversion per cycle and stalls without loss when the consumer back-pressures.

## Interface

- No parameters; all widths are fixed.
- clk  input  1  clock, rising-edge.
- rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand on in_x is valid.
- in_ready  output  1  block accepts the operand this cycle.
- in_x  input  32  binary32 operand.
- out_valid  output  1  out_y and out_flags are valid.
- out_ready  input  1  consumer takes the result this cycle.
- out_y  output  32  signed integer result.
- out_flags  output  2  bit1 invalid (NaN, infinity, out of range); bit0 inexact (fraction discarded).

## Operation

- Fields: s = x[31], e = x[30:23], m = {1, x[22:0]} when e != 0.
- Classification and result:
  - e == 0, including zero and denormals: y = 0, flags = 00. Signed zero gives 0.
  - e <= 125 (|x| < 0.5): y = 0, inexact = 1.
  - 126 <= e <= 157: convert with round-to-nearest, ties away from zero.
    - Compute the 32-bit magnitude from m shifted by (e - 150).
    - Add the first discarded bit.
    - Negate if s = 1.
    - inexact = 1 if any discarded bit is nonzero.
  - e == 158 with s = 1 and x[22:0] == 0 (exactly -2^31): y = 0x80000000, flags = 00.
  - e >= 158 otherwise, including infinity: saturate. y = 0x7FFFFFFF if s = 0, else 0x80000000; invalid = 1.
  - NaN (e == 255, fraction != 0): y = 0x7FFFFFFF regardless of sign; invalid = 1.
- Rounding never overflows for e <= 157, because the largest finite value below 2^31 is 2147483520.
- Stage 1 (s1) registers:
  - sign
  - class code: zero, small, normal, saturate-positive, saturate-negative, nan
  - 24-bit significand
  - 5-bit shift amount
- Stage 2 (s2) is the output register. It holds the result of the shift, round and negate, plus flags.

## Timing

- Reset (asynchronous, rstn low): s1_valid = 0, out_valid = 0, out_y = 0, out_flags = 0, and all internal data registers = 0.
  - Any operand in flight is discarded without producing a result.
  - in_ready is 1 while out_valid = 0.
  - The first accept can occur on the first rising edge after rstn deasserts.
- Load conditions:
  - s2_load = ~out_valid | out_ready.
  - s1_load = ~s1_valid | s2_load.
  - in_ready = s1_load. This combinational path from out_ready to in_ready is intended.
- Accept: the operand is accepted on a rising edge where in_valid & in_ready.
- Latency: an operand accepted at edge N appears with out_valid = 1 after edge N+1, when the consumer is ready.
- Throughput: 1 per cycle with out_ready held high.
- Stall: while out_valid & ~out_ready, out_y and out_flags hold stable. s1 keeps at most one further operand, then in_ready = 0.
- Valid propagation when s2_load is high: s2 valid takes s1_valid, and s1_valid takes (in_valid & in_ready). Bubbles collapse.
- Simultaneous accept and drain in the same cycle is legal. No result is lost or duplicated.
- in_x is sampled only on accept. in_x is don't-care otherwise.

## Test plan

- Basic values with out_ready = 1, issuing 1.0, -1.0, 0x4B000001, 0x00000000, 0x80000000 back-to-back:
  - 0x3F800000 -> 0x00000001, flags 00.
  - 0xBF800000 -> 0xFFFFFFFF, flags 00.
  - 0x4B000001 -> 0x00800001, flags 00.
  - 0x00000000 -> 0x00000000, flags 00.
  - 0x80000000 -> 0x00000000, flags 00.
  - Results arrive in order on consecutive cycles, 2 edges after issue.
- Rounding:
  - 2.5 (0x40200000) -> 3, flags 01.
  - -2.5 (0xC0200000) -> -3 (0xFFFFFFFD), flags 01.
  - 0.5 (0x3F000000) -> 1, flags 01.
  - 0.4999 (0x3EFFFFFF) -> 0, flags 01.
  - 1.25 (0x3FA00000) -> 1, flags 01.
- Range limits:
  - 0x4EFFFFFF -> 0x7FFFFF80, flags 00.
  - 0x4F000000 -> 0x7FFFFFFF, flags 10.
  - 0xCF000000 -> 0x80000000, flags 00.
  - 0xCF000001 -> 0x80000000, flags 10.
  - 0x7F800000 -> 0x7FFFFFFF, flags 10.
  - 0xFF800000 -> 0x80000000, flags 10.
  - 0xFFC00000 (NaN) -> 0x7FFFFFFF, flags 10.
  - 0x00000001 (denormal) -> 0, flags 00.
- Back-pressure:
  - Stimulus: stream values 1..8 as floats with in_valid = 1 continuously, out_ready low for 5 cycles mid-stream.
  - Required: in_ready drops after 2 operands are held; out_y is stable during the stall; all 8 results 1..8 arrive in order with no drop or duplicate.
- Random with bubbles: 10k random operands with random in_valid and out_ready gaps, compared against a scoreboard reference model -> zero mismatches.
- Reset mid-stream:
  - Stimulus: assert rstn low asynchronously between edges with 2 operands in flight.
  - Required: out_valid and out_y go to 0 immediately; after release, the next operand 7.0 (0x40E00000) yields 7 with no stale result emitted.
